contador_seq_ctrl: RTL and testbench

Synchronous command sequencer that drives the 4-bit up/down counter's asynchronous control pins (MR, PL, CPU, CPD, P0..P3) from a single system clock. It accepts CLEAR, LOAD, UP-by-N and DOWN-by-N commands over a valid/ready handshake and generates glitch-free, width-controlled pulses on the counter pins. It then snapshots the counter outputs, flags terminal-count wrap from TCU/TCD, and checks the result against an internal shadow count.

---
 rtl/contador_seq_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_contador_seq_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/contador_seq_ctrl.sv
// contador_seq_ctrl: synchronous command sequencer for a 4-bit up/down counter.
// The controller turns CLEAR / LOAD / UP-by-N / DOWN-by-N commands into
// width-controlled pulses on the counter's asynchronous pins (MR, PL, CPU, CPD, P).
// When each command ends, it snapshots Q and flags a terminal-count wrap.
// It also compares Q against an internal shadow count.
// Every output comes from a register, so no input reaches an output combinationally.
module contador_seq_ctrl #(
  parameter int PULSE_W    = 1,  // cycles per pulse phase, 1..15
  parameter int SETTLE_CYC = 1   // idle cycles before Q is sampled, 1..15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cmd_valid,
  output logic       o_cmd_ready,
  input  logic [1:0] i_cmd_op,
  input  logic [3:0] i_cmd_data,
  output logic       o_mr,
  output logic       o_pl,
  output logic       o_cpu,
  output logic       o_cpd,
  output logic [3:0] o_p,
  input  logic [3:0] i_q,
  input  logic       i_tcu,
  input  logic       i_tcd,
  output logic       o_done,
  output logic [3:0] o_q_snap,
  output logic       o_wrap,
  output logic       o_mismatch
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LD,
    S_CLK_LO,
    S_CLK_HI,
    S_SETTLE,
    S_FIN
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;

  // Phase counters run from 0 up to these values inclusive.
  localparam logic [3:0] PW_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] ST_LAST = 4'(SETTLE_CYC - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_rem;
  logic       r_is_down;
  logic       r_wrap_seen;
  logic [3:0] r_shadow;
  logic       r_shadow_valid;
  logic       r_ready;
  logic       r_mr;
  logic       r_pl;
  logic       r_cpu;
  logic       r_cpd;
  logic [3:0] r_p;
  logic       r_done;
  logic [3:0] r_q_snap;
  logic       r_wrap;
  logic       r_mismatch;

  logic       w_accept;
  logic       w_pw_end;
  logic       w_st_end;
  logic [3:0] w_rem_dec;
  logic       w_tc_low;

  assign w_accept  = i_cmd_valid && r_ready && (r_state == S_IDLE);
  assign w_pw_end  = (r_cnt == PW_LAST);
  assign w_st_end  = (r_cnt == ST_LAST);
  assign w_rem_dec = r_rem - 4'd1;
  // Terminal count of the direction in use (both pins are active low).
  assign w_tc_low  = r_is_down ? ~i_tcd : ~i_tcu;

  // Main sequencer: state, phase timing and all registered pin/status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rem       <= 4'd0;
      r_is_down   <= 1'b0;
      r_wrap_seen <= 1'b0;
      r_ready     <= 1'b1;
      r_mr        <= 1'b0;
      r_pl        <= 1'b1;
      r_cpu       <= 1'b1;
      r_cpd       <= 1'b1;
      r_p         <= 4'd0;
      r_done      <= 1'b0;
      r_q_snap    <= 4'd0;
      r_wrap      <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ready     <= 1'b0;
            r_wrap_seen <= 1'b0;
            r_cnt       <= 4'd0;
            r_is_down   <= i_cmd_op[0];
            r_rem       <= i_cmd_data;
            case (i_cmd_op)
              OP_CLEAR: begin
                r_mr    <= 1'b1;
                r_state <= S_CLR;
              end
              OP_LOAD: begin
                r_p     <= i_cmd_data;
                r_pl    <= 1'b0;
                r_state <= S_LD;
              end
              default: begin
                if (i_cmd_data != 4'd0) begin
                  // The first clock fall happens on the acceptance edge.
                  if (i_cmd_op[0]) r_cpd <= 1'b0;
                  else             r_cpu <= 1'b0;
                  r_state <= S_CLK_LO;
                end else begin
                  r_state <= S_SETTLE;
                end
              end
            endcase
          end
        end

        S_CLR: begin
          if (w_pw_end) begin
            r_mr    <= 1'b0;
            r_cnt   <= 4'd0;
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_LD: begin
          if (w_pw_end) begin
            r_pl    <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= S_SETTLE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_CLK_LO: begin
          // The counter only flags terminal count while its clock is low.
          if (w_tc_low) r_wrap_seen <= 1'b1;
          if (w_pw_end) begin
            r_cpu   <= 1'b1;
            r_cpd   <= 1'b1;
            r_cnt   <= 4'd0;
            r_state <= S_CLK_HI;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_CLK_HI: begin
          if (w_pw_end) begin
            r_rem <= w_rem_dec;
            r_cnt <= 4'd0;
            if (w_rem_dec != 4'd0) begin
              if (r_is_down) r_cpd <= 1'b0;
              else           r_cpu <= 1'b0;
              r_state <= S_CLK_LO;
            end else begin
              r_state <= S_SETTLE;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_SETTLE: begin
          if (w_st_end) begin
            r_done     <= 1'b1;
            r_q_snap   <= i_q;
            r_wrap     <= r_wrap_seen;
            r_mismatch <= r_shadow_valid && (i_q != r_shadow);
            r_state    <= S_FIN;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end

        S_FIN: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_mr    <= 1'b0;
          r_pl    <= 1'b1;
          r_cpu   <= 1'b1;
          r_cpd   <= 1'b1;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Shadow of the expected counter value, advanced when each command is accepted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow       <= 4'd0;
      r_shadow_valid <= 1'b0;
    end else if (w_accept) begin
      case (i_cmd_op)
        OP_CLEAR: begin
          r_shadow       <= 4'd0;
          r_shadow_valid <= 1'b1;
        end
        OP_LOAD: begin
          r_shadow       <= i_cmd_data;
          r_shadow_valid <= 1'b1;
        end
        2'b10:   r_shadow <= r_shadow + i_cmd_data;
        default: r_shadow <= r_shadow - i_cmd_data;
      endcase
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_mr        = r_mr;
  assign o_pl        = r_pl;
  assign o_cpu       = r_cpu;
  assign o_cpd       = r_cpd;
  assign o_p         = r_p;
  assign o_done      = r_done;
  assign o_q_snap    = r_q_snap;
  assign o_wrap      = r_wrap;
  assign o_mismatch  = r_mismatch;

endmodule

// File: tb/tb_contador_seq_ctrl.sv
// Directed testbench for contador_seq_ctrl with a behavioural 4-bit up/down counter model.
module tb_contador_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       mr, pl, cpu, cpd;
  logic [3:0] p;
  logic [3:0] cq;
  logic       tcu, tcd;
  logic       done;
  logic [3:0] q_snap;
  logic       wrap, mismatch;

  int n_chk  = 0;
  int n_fail = 0;

  contador_seq_ctrl #(.PULSE_W(1), .SETTLE_CYC(1)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_op   (cmd_op),
    .i_cmd_data (cmd_data),
    .o_mr       (mr),
    .o_pl       (pl),
    .o_cpu      (cpu),
    .o_cpd      (cpd),
    .o_p        (p),
    .i_q        (cq),
    .i_tcu      (tcu),
    .i_tcd      (tcd),
    .o_done     (done),
    .o_q_snap   (q_snap),
    .o_wrap     (wrap),
    .o_mismatch (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model: terminal-count outputs are active low while the relevant clock is low.
  assign tcu = !((cq == 4'hF) && !cpu);
  assign tcd = !((cq == 4'h0) && !cpd);

  // Counter model state and pin monitors, evaluated mid-cycle.
  logic prev_cpu = 1'b1;
  logic prev_cpd = 1'b1;
  int   skip_req = 0, skip_taken = 0;
  int   mon_mr = 0, mon_pl = 0, mon_cpu_fall = 0, mon_cpd_fall = 0, mon_viol = 0, mon_done = 0;
  initial cq = 4'h0;

  always @(negedge clk) begin
    if (mr) cq = 4'h0;
    else if (!pl) cq = p;
    else if (!prev_cpu && cpu) begin
      if (skip_req > skip_taken) skip_taken++;
      else cq = cq + 4'd1;
    end else if (!prev_cpd && cpd) cq = cq - 4'd1;
    if (mr) mon_mr++;
    if (!pl) mon_pl++;
    if (prev_cpu && !cpu) mon_cpu_fall++;
    if (prev_cpd && !cpd) mon_cpd_fall++;
    if ((!cpu && !cpd) || ((mr || !pl) && (!cpu || !cpd))) mon_viol++;
    if (done) mon_done++;
    prev_cpu = cpu;
    prev_cpd = cpd;
  end

  // Cycle counter and acceptance monitor; inputs are stable at the rising edge.
  int cyc = 0, acc_cnt = 0, acc_last = 0;
  always @(posedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready && rst_n) begin
      acc_cnt++;
      acc_last = cyc;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  int acc_cyc, done_cyc;
  int s_mr, s_pl, s_cpu, s_cpd;

  task automatic issue(input logic [1:0] op, input logic [3:0] data);
    int a0, g;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    a0 = acc_cnt;
    g  = 0;
    while (acc_cnt == a0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    check_val("accepted", acc_cnt - a0, 1);
    cmd_valid = 1'b0;
    acc_cyc   = acc_last;
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (!done && g < 200) begin
      @(negedge clk);
      g++;
    end
    check_val("done_seen", done, 1);
    done_cyc = cyc;
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] data,
                         input int lat, input logic [3:0] exp_q, input logic exp_w, input logic exp_m);
    s_mr = mon_mr; s_pl = mon_pl; s_cpu = mon_cpu_fall; s_cpd = mon_cpd_fall;
    issue(op, data);
    wait_done();
    check_val({tag, "_lat"}, done_cyc - acc_cyc, lat);
    check_val({tag, "_qsnap"}, q_snap, exp_q);
    check_val({tag, "_wrap"}, wrap, exp_w);
    check_val({tag, "_mismatch"}, mismatch, exp_m);
    @(negedge clk);
    check_val({tag, "_done_1cyc"}, done, 0);
    $display("cmd %s op=%0d data=%0h lat=%0d qsnap=%0h wrap=%0b mm=%0b",
             tag, op, data, done_cyc - acc_cyc, q_snap, wrap, mismatch);
  endtask

  initial begin
    int a1, d0, g;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 4'h0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", cmd_ready, 1);
    check_val("rst_pins", {mr, pl, cpu, cpd, p}, {1'b0, 1'b1, 1'b1, 1'b1, 4'h0});
    check_val("rst_status", {done, q_snap, wrap, mismatch}, 7'd0);
    rst_n = 1'b1;

    run_cmd("clear", 2'b00, 4'h0, 2, 4'h0, 0, 0);
    check_val("clear_mr_cycles", mon_mr - s_mr, 1);

    run_cmd("load_a", 2'b01, 4'hA, 2, 4'hA, 0, 0);
    check_val("load_p", p, 4'hA);
    check_val("load_pl_cycles", mon_pl - s_pl, 1);

    run_cmd("load_e", 2'b01, 4'hE, 2, 4'hE, 0, 0);
    run_cmd("up3", 2'b10, 4'd3, 7, 4'h1, 1, 0);
    check_val("up3_cpu_pulses", mon_cpu_fall - s_cpu, 3);
    check_val("up3_cpd_pulses", mon_cpd_fall - s_cpd, 0);
    check_val("p_holds", p, 4'hE);

    run_cmd("clear2", 2'b00, 4'h0, 2, 4'h0, 0, 0);
    run_cmd("down1", 2'b11, 4'd1, 3, 4'hF, 1, 0);
    check_val("down1_cpd_pulses", mon_cpd_fall - s_cpd, 1);
    run_cmd("up0", 2'b10, 4'd0, 1, 4'hF, 0, 0);
    check_val("up0_pulses", (mon_cpu_fall - s_cpu) + (mon_cpd_fall - s_cpd), 0);

    run_cmd("load5", 2'b01, 4'h5, 2, 4'h5, 0, 0);
    skip_req++;
    run_cmd("up2_skip", 2'b10, 4'd2, 5, 4'h6, 0, 1);

    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    skip_req++;
    run_cmd("up2_noshadow", 2'b10, 4'd2, 5, 4'h7, 0, 0);

    // Abort a DOWN 8 with reset while CPD is low.
    issue(2'b11, 4'd8);
    repeat (4) @(negedge clk);
    g = 0;
    while (cpd && g < 20) begin
      @(negedge clk);
      g++;
    end
    check_val("abort_cpd_low_seen", cpd, 0);
    d0 = mon_done;
    rst_n = 1'b0;
    #1;
    check_val("abort_cpd", cpd, 1);
    check_val("abort_ready", cmd_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_val("abort_no_done", mon_done - d0, 0);
    $display("cmd abort_down8 done_count=%0d", mon_done - d0);

    // A command held valid while busy is taken exactly once, right after FIN.
    issue(2'b00, 4'h0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = 4'h9;
    a1 = acc_cnt;
    wait_done();
    check_val("held_clear_qsnap", q_snap, 4'h0);
    check_val("held_no_early_accept", acc_cnt - a1, 0);
    g = 0;
    while (acc_cnt == a1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    cmd_valid = 1'b0;
    check_val("held_accept_count", acc_cnt - a1, 1);
    check_val("held_accept_cycle", acc_last - done_cyc, 2);
    acc_cyc = acc_last;
    wait_done();
    check_val("held_load_lat", done_cyc - acc_cyc, 2);
    check_val("held_load_qsnap", q_snap, 4'h9);
    check_val("held_load_mismatch", mismatch, 0);
    repeat (5) @(negedge clk);
    check_val("held_accept_once", acc_cnt - a1, 1);
    $display("cmd held_load9 accepts=%0d qsnap=%0h", acc_cnt - a1, q_snap);

    check_val("pin_overlap", mon_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
